row_write_ctrl: RTL and testbench
=================================

ROW_WRITE_CTRL -- requirements
Module: row_write_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: req_valid  input  1  request present.
REQ-004 SHALL have: req_ready  output  1  controller can accept a request this cycle.
REQ-005 SHALL have: req_op  input  1  0 = single-row write, 1 = clear-all sweep.
REQ-006 SHALL have: req_addr  input  3  target row for write.
REQ-007 SHALL have: req_data  input  8  write data.
REQ-008 SHALL have: addr  output  3  row address to the 3-to-8 row decoder.
REQ-009 SHALL have: nen  output  1  active-low decoder enable; 1 = no row selected.
REQ-010 SHALL have: din  output  8  data bus to the row registers.
REQ-011 SHALL have: ld  output  1  load strobe to the row registers.
REQ-012 SHALL have: busy  output  1  high in any non-IDLE state.
REQ-013 SHALL have: done  output  1  one-cycle pulse on the final load of an operation.
REQ-014 Parameters: ROWS, default 8, row count; WIDTH, default 8, data width; both fixed at these values for this revision.

Function
REQ-015 SHALL implement FSM states IDLE, WRITE, CLEAR.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
REQ-017 req_op, req_addr, req_data SHALL be captured only on acceptance; inputs are ignored while req_ready = 0.
REQ-018 Accept with req_op = 0: IDLE -> WRITE; in the next cycle addr = captured addr, din = captured data, nen = 0, ld = 1, done = 1 for exactly one cycle; then WRITE -> IDLE.
REQ-019 Accept with req_op = 1: IDLE -> CLEAR; for 8 consecutive cycles addr = 0,1,...,7, din = 0, nen = 0, ld = 1; done = 1 only in the addr = 7 cycle; then CLEAR -> IDLE.
REQ-020 Sweep counter SHALL be 3 bits, start at 0 on entry to CLEAR, and terminate the sweep at 7; it does not wrap into a second pass.
REQ-021 In IDLE outputs SHALL be nen = 1, ld = 0, done = 0, din = 0, addr = 0.
REQ-022 All outputs SHALL be registered (driven from flops, no combinational input-to-output path).
REQ-023 Latency: write accepted at edge N -> ld high in the cycle after edge N; req_ready high again after edge N+1; throughput one write per 2 cycles.
REQ-024 Clear latency: accepted at edge N -> ld high cycles N+1..N+8; req_ready high after edge N+8.
REQ-025 req_valid held high continuously SHALL be accepted again on the first IDLE cycle, no extra bubble.
REQ-026 ld = 1 SHALL always coincide with nen = 0; nen = 0 SHALL never occur without ld = 1.

Reset
REQ-027 rst = 1 SHALL asynchronously force state IDLE, counter 0, captured registers 0, and outputs per REQ-021 with req_ready = 1, busy = 0.
REQ-028 rst asserted mid-WRITE or mid-CLEAR SHALL abort immediately with no further ld pulses and no done pulse; no resume after release.
REQ-029 First acceptance after rst deasserts SHALL occur no earlier than the first rising edge with rst = 0.

Structure
REQ-030 Shared package SHALL hold: state enum (IDLE, WRITE, CLEAR), op constants OP_WRITE = 0, OP_CLEAR = 1, ROWS, WIDTH.
REQ-031 Sweep counter SHALL be a sub-module row_counter (3-bit, enable, synchronous clear, terminal-count output, async reset).
REQ-032 FSM, capture registers and output registers reside in row_write_ctrl.

Verification
REQ-033 Reset: rst = 1 with random inputs -> nen = 1, ld = 0, req_ready = 1, busy = 0, done = 0 within the same cycle.
REQ-034 Write: req_op = 0, req_addr = 5, req_data = 8'hA5 accepted -> next cycle addr = 5, din = 8'hA5, nen = 0, ld = 1, done = 1; ld low on the following cycle.
REQ-035 Clear: req_op = 1 accepted -> 8 cycles of ld = 1, din = 0, addr 0..7 in order; done only at addr = 7; req_ready returns 1 afterward.
REQ-036 Back-to-back: req_valid held high with writes to rows 1, 2, 3 -> ld pulses 2 cycles apart, addr 1, 2, 3; inputs changed while busy have no effect.
REQ-037 Abort: rst pulsed at clear-sweep cycle addr = 3 -> ld drops immediately, no done, addr = 0, req_ready = 1 after release.
REQ-038 Assertion throughout all tests: ld == ~nen, and done implies ld.

Source files
------------

// File: rtl/row_write_ctrl_pkg.sv
// Shared types and constants for the row write controller.
package row_write_ctrl_pkg;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned ADDR_W = $clog2(ROWS);

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_CLEAR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/row_write_ctrl_counter.sv
// Sweep counter for the clear-all operation; holds at its terminal value.
module row_counter
    import row_write_ctrl_pkg::*;
#(
    parameter int unsigned W = ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    // Count register: clear has priority so every sweep starts from row 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc_c = &cnt;

endmodule

// File: rtl/row_write_ctrl.sv
// Row write controller: single-row writes and an 8-row clear sweep into a decoded register file.
module row_write_ctrl #(
    parameter int unsigned ROWS  = row_write_ctrl_pkg::ROWS,
    parameter int unsigned WIDTH = row_write_ctrl_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [$clog2(ROWS)-1:0]  req_addr,
    input  logic [WIDTH-1:0]         req_data,
    output logic [$clog2(ROWS)-1:0]  addr,
    output logic                     nen,
    output logic [WIDTH-1:0]         din,
    output logic                     ld,
    output logic                     busy,
    output logic                     done
);
    import row_write_ctrl_pkg::*;

    localparam int unsigned AW = $clog2(ROWS);

    state_t          state;
    logic            accept;
    logic [AW-1:0]   cnt;
    logic            cnt_tc;

    assign accept = req_valid && req_ready;

    row_counter #(
        .W (AW)
    ) u_row_counter (
        .clk  (clk),
        .rst  (rst),
        .en   ((state == CLEAR) && !cnt_tc),
        .clr  (accept),
        .cnt  (cnt),
        .tc_c (cnt_tc)
    );

    // FSM with registered outputs; addr/din flops also act as the request capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            addr      <= '0;
            din       <= '0;
            nen       <= 1'b1;
            ld        <= 1'b0;
            done      <= 1'b0;
        end else begin
            addr <= '0;
            din  <= '0;
            nen  <= 1'b1;
            ld   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        nen       <= 1'b0;
                        ld        <= 1'b1;
                        unique case (req_op)
                            OP_WRITE: begin
                                state <= WRITE;
                                addr  <= req_addr;
                                din   <= req_data;
                                done  <= 1'b1;
                            end
                            OP_CLEAR: begin
                                state <= CLEAR;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                CLEAR: begin
                    if (cnt_tc) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        nen  <= 1'b0;
                        ld   <= 1'b1;
                        addr <= cnt + AW'(1);
                        done <= (cnt == AW'(ROWS - 2));
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_row_write_ctrl.sv
// Self-checking bench for row_write_ctrl: vector table, reset/abort sequences, random traffic vs a queue model.
module tb_row_write_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [2:0] req_addr;
    logic [7:0] req_data;
    logic [2:0] addr;
    logic       nen;
    logic [7:0] din;
    logic       ld;
    logic       busy;
    logic       done;

    int n_pass;
    int n_total;

    row_write_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .addr      (addr),
        .nen       (nen),
        .din       (din),
        .ld        (ld),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {req_ready, busy, nen, ld, done, addr, din};

    // Expected output vector: nen is always the inverse of ld
    function automatic logic [15:0] pk(input logic rdy, input logic bsy, input logic l,
                                       input logic dn, input logic [2:0] a, input logic [7:0] d);
        return {rdy, bsy, ~l, l, dn, a, d};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got rdy/busy/nen/ld/done/addr/din=%h required %h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: each accepted request expands into a queue of load beats shown one per cycle
    typedef struct packed {
        logic [2:0] a;
        logic [7:0] d;
        logic       dn;
    } beat_t;

    beat_t mq[$];
    beat_t cur;
    bit    cur_v;

    task automatic model_reset();
        mq.delete();
        cur   = '0;
        cur_v = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic op, input logic [2:0] a, input logic [7:0] d);
        if (cur_v) begin
            if (mq.size() > 0) cur = mq.pop_front();
            else cur_v = 1'b0;
        end else if (v) begin
            if (op == 1'b0) begin
                mq.push_back('{a: a, d: d, dn: 1'b1});
            end else begin
                for (int i = 0; i < 8; i++) mq.push_back('{a: 3'(i), d: 8'h00, dn: 1'(i == 7)});
            end
            cur   = mq.pop_front();
            cur_v = 1'b1;
        end
    endtask

    function automatic logic [15:0] model_exp();
        if (cur_v) return pk(1'b0, 1'b1, 1'b1, cur.dn, cur.a, cur.d);
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endfunction

    task automatic step(input logic v, input logic op, input logic [2:0] a, input logic [7:0] d);
        req_valid = v;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        model_edge(v, op, a, d);
        #1;
    endtask

    // Decoder enable must track the load strobe, and done only appears with a load
    always @(negedge clk) begin
        n_total++;
        if ((ld === ~nen) && (!done || ld)) n_pass++;
        else $display("FAIL strobe_invariant: ld=%b nen=%b done=%b required ld==~nen and done->ld at %0t",
                      ld, nen, done, $time);
    end

    typedef struct packed {
        logic        v;
        logic        op;
        logic [2:0]  a;
        logic [7:0]  d;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic v, input logic op, input logic [2:0] a,
                                input logic [7:0] d, input logic [15:0] exp);
        return '{v: v, op: op, a: a, d: d, exp: exp};
    endfunction

    initial begin
        logic [15:0] idle_exp;
        n_pass   = 0;
        n_total  = 0;
        idle_exp = pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        model_reset();

        // Asynchronous reset with random inputs
        rst       = 1'b0;
        req_valid = 1'($urandom);
        req_op    = 1'($urandom);
        req_addr  = 3'($urandom);
        req_data  = 8'($urandom);
        #1 rst = 1'b1;
        #1 check("reset_async", obs, idle_exp);
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_op    = 1'($urandom);
            req_addr  = 3'($urandom);
            req_data  = 8'($urandom);
            @(posedge clk);
            #1 check("reset_hold", obs, idle_exp);
        end
        rst = 1'b0;

        // Vector table: write, ignored-while-busy, clear sweep, back-to-back writes
        tbl[0] = mk(1'b1, 1'b0, 3'd5, 8'hA5, pk(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 8'hA5));
        tbl[1] = mk(1'b1, 1'b1, 3'd2, 8'h33, idle_exp);
        tbl[2] = mk(1'b0, 1'b0, 3'd0, 8'h00, idle_exp);
        tbl[3] = mk(1'b1, 1'b1, 3'd7, 8'hFF, pk(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00));
        for (int i = 4; i <= 10; i++)
            tbl[i] = mk(1'b1, 1'b0, 3'(i), 8'h5A, pk(1'b0, 1'b1, 1'b1, 1'(i == 10), 3'(i - 3), 8'h00));
        tbl[11] = mk(1'b0, 1'b0, 3'd0, 8'h00, idle_exp);
        tbl[12] = mk(1'b1, 1'b0, 3'd1, 8'h11, pk(1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h11));
        tbl[13] = mk(1'b1, 1'b0, 3'd6, 8'h66, idle_exp);
        tbl[14] = mk(1'b1, 1'b0, 3'd2, 8'h22, pk(1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 8'h22));
        tbl[15] = mk(1'b1, 1'b1, 3'd0, 8'h77, idle_exp);
        tbl[16] = mk(1'b1, 1'b0, 3'd3, 8'h33, pk(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h33));
        tbl[17] = mk(1'b0, 1'b0, 3'd0, 8'h00, idle_exp);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        // Abort a clear sweep at row 3 with an asynchronous reset
        step(1'b1, 1'b1, 3'd0, 8'h00);
        check("abort_row0", obs, pk(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00));
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 8'h00);
            check("abort_sweep", obs, pk(1'b0, 1'b1, 1'b1, 1'b0, 3'(i), 8'h00));
        end
        #2 rst = 1'b1;
        model_reset();
        #1 check("abort_async", obs, idle_exp);
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_addr  = 3'd4;
        req_data  = 8'hC3;
        @(posedge clk);
        #1 check("abort_hold", obs, idle_exp);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'h00);
            check("abort_no_resume", obs, idle_exp);
        end

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 3'($urandom), 8'($urandom));
            check("rand", obs, model_exp());
        end

        req_valid = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
